// File: rtl/reg_port_arbiter.sv
// Round-robin arbiter sharing one register-interface port among NREQ requesters,
// with req/gnt/ack handshake, owner lock for atomic RMW and a bounded lock hold time.
module reg_port_arbiter #(
    parameter int NREQ     = 3,
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int LOCK_MAX = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      ir_req,
    input  logic [NREQ-1:0]      ir_wr,
    input  logic [NREQ-1:0]      ir_lock,
    input  logic [NREQ*AW-1:0]   ir_addr,
    input  logic [NREQ*DW-1:0]   ir_wdata,
    output logic [NREQ-1:0]      ow_gnt,
    output logic [NREQ-1:0]      ow_ack,
    output logic [DW-1:0]        ow_rdata,
    output logic [AW-1:0]        ow_reg_address,
    output logic [DW-1:0]        ow_reg_in_data,
    output logic                 ow_reg_enb,
    input  logic [DW-1:0]        ir_reg_out_data,
    output logic                 ow_lock_err
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, ACK, HOLD} state_t;

    state_t        state;
    logic [OW-1:0] owner;
    logic [OW-1:0] last;
    logic [CW-1:0] cnt;
    logic [OW-1:0] pick;
    logic [OW-1:0] cand;
    logic          found;

    // First requester found when searching last+1, last+2, ... modulo NREQ.
    always_comb begin
        pick  = last;
        cand  = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = OW'((32'(last) + i) % NREQ);
            if (!found && ir_req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            owner          <= '0;
            last           <= OW'(NREQ - 1);
            cnt            <= '0;
            ow_gnt         <= '0;
            ow_ack         <= '0;
            ow_rdata       <= '0;
            ow_reg_address <= '0;
            ow_reg_in_data <= '0;
            ow_reg_enb     <= 1'b0;
            ow_lock_err    <= 1'b0;
        end else begin
            ow_ack     <= '0;
            ow_reg_enb <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|ir_req) begin
                        owner          <= pick;
                        last           <= pick;
                        ow_gnt         <= NREQ'(1) << pick;
                        ow_reg_address <= ir_addr[pick*AW +: AW];
                        ow_reg_in_data <= ir_wdata[pick*DW +: DW];
                        ow_reg_enb     <= ir_wr[pick];
                        state          <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Sampled on the same edge the write commits, so writes return the old value.
                    ow_rdata <= ir_reg_out_data;
                    ow_ack   <= NREQ'(1) << owner;
                    state    <= ACK;
                end
                ACK: begin
                    if (ir_lock[owner]) begin
                        cnt   <= '0;
                        state <= HOLD;
                    end else begin
                        ow_gnt <= '0;
                        state  <= IDLE;
                    end
                end
                HOLD: begin
                    if (ir_req[owner]) begin
                        ow_reg_address <= ir_addr[owner*AW +: AW];
                        ow_reg_in_data <= ir_wdata[owner*DW +: DW];
                        ow_reg_enb     <= ir_wr[owner];
                        state          <= ACCESS;
                    end else if (!ir_lock[owner]) begin
                        ow_gnt <= '0;
                        state  <= IDLE;
                    end else if (cnt == CW'(LOCK_MAX - 1)) begin
                        ow_gnt      <= '0;
                        ow_lock_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
